// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter sharing one memory block between NREQ requesters.
// Optional MEMCTL_RETRY_EN: grants blocked by full/empty wait in HOLD up to RETRY_MAX cycles.
module mem_req_arbiter #(
  parameter int NREQ = 4,
  parameter int RD_LAT = 1,
  parameter int RETRY_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [2*NREQ-1:0] req_chip,
  input  logic [3*NREQ-1:0] req_mode,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       Din,
  output logic [2:0]        mode_in,
  output logic [2:0]        chip_en,
  output logic [1:0]        rw,
  output logic              mem_reset,
  input  logic [31:0]       Dout,
  input  logic              full,
  input  logic              empty
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CMAX = RD_LAT > RETRY_MAX ? RD_LAT : RETRY_MAX;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP
`ifdef MEMCTL_RETRY_EN
    , HOLD
`endif
  } state_t;
  state_t state, nxt;
  logic [PW-1:0] rr_ptr, gnt, owner;
  logic hit, ill, blk, err_q, err_n, clr_q;
  logic [1:0] op_g, chip_g, op_q, chip_q, op_n, chip_n;
  logic [CW-1:0] cnt;
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        gnt = PW'((int'(rr_ptr) + i) % NREQ);
        hit = 1'b1;
      end
  end
  assign op_g = req_op[2*gnt +: 2];
  assign chip_g = req_chip[2*gnt +: 2];
  assign ill = op_g == 2'b11 || chip_g == 2'b11;
  assign blk = (op_g == 2'b01 && full) || (op_g == 2'b00 && empty);
  assign req_ready = (state == IDLE && hit && !reset) ? NREQ'(1) << gnt : '0;
  assign rsp_valid = state == RESP ? NREQ'(1) << owner : '0;
  assign rsp_err = state == RESP && err_q;
  assign mem_reset = reset | clr_q;
`ifdef MEMCTL_RETRY_EN
  logic hold_blk;
  assign hold_blk = (op_q == 2'b01 && full) || (op_q == 2'b00 && empty);
`endif
  always_comb begin
    nxt = state;
    err_n = err_q;
    op_n = op_q;
    chip_n = chip_q;
    case (state)
      IDLE: if (hit) begin
        op_n = op_g;
        chip_n = chip_g;
`ifdef MEMCTL_RETRY_EN
        err_n = ill;
        nxt = ill ? RESP : blk ? HOLD : ISSUE;
`else
        err_n = ill | blk;
        nxt = (ill | blk) ? RESP : ISSUE;
`endif
      end
      ISSUE: nxt = op_q == 2'b00 ? WAIT : RESP;
      WAIT: nxt = cnt == CW'(RD_LAT - 1) ? RESP : WAIT;
`ifdef MEMCTL_RETRY_EN
      HOLD: begin
        err_n = hold_blk;
        nxt = !hold_blk ? ISSUE : cnt == CW'(RETRY_MAX - 1) ? RESP : HOLD;
      end
`endif
      default: nxt = IDLE;
    endcase
  end
  // strobe registers load on the edge entering ISSUE so they are valid for exactly that cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      op_q <= '0;
      chip_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
      rsp_rdata <= '0;
      Din <= '0;
      mode_in <= '0;
      chip_en <= '0;
      rw <= '0;
      clr_q <= 1'b0;
    end else begin
      state <= nxt;
      op_q <= op_n;
      chip_q <= chip_n;
      err_q <= err_n;
      cnt <= nxt == state ? cnt + CW'(1) : '0;
      rw <= nxt != ISSUE ? 2'b00 : op_n == 2'b00 ? 2'b10 : op_n == 2'b01 ? 2'b01 : 2'b00;
      chip_en <= (nxt == ISSUE && !op_n[1]) ? 3'b001 << chip_n : 3'b000;
      clr_q <= nxt == ISSUE && op_n == 2'b10;
      if (state == IDLE && hit) begin
        owner <= gnt;
        rr_ptr <= gnt == PW'(NREQ - 1) ? '0 : gnt + PW'(1);
        mode_in <= req_mode[3*gnt +: 3];
        Din <= req_wdata[32*gnt +: 32];
        rsp_rdata <= '0;
      end else if (state == WAIT && nxt == RESP) rsp_rdata <= Dout;
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed stimulus checked every cycle against a cycle-indexed expectation model.
module tb_mem_req_arbiter;
  localparam int NREQ = 4;
  localparam int RD_LAT = 1;
  localparam int RETRY_MAX = 15;
  localparam int D = 1024;
  logic clk, reset;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [2*NREQ-1:0] req_op, req_chip;
  logic [3*NREQ-1:0] req_mode;
  logic [32*NREQ-1:0] req_wdata;
  logic [31:0] rsp_rdata, Din, Dout;
  logic rsp_err, mem_reset, full, empty;
  logic [2:0] mode_in, chip_en;
  logic [1:0] rw;
  int checks = 0;
  int errors = 0;
  mem_req_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .RETRY_MAX(RETRY_MAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_chip(req_chip), .req_mode(req_mode), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .Din(Din),
    .mode_in(mode_in), .chip_en(chip_en), .rw(rw), .mem_reset(mem_reset),
    .Dout(Dout), .full(full), .empty(empty));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // expected outputs per cycle index; cycle k begins at the k-th rising edge
  bit [1:0] e_rw [D];
  bit [2:0] e_ce [D];
  bit e_clr [D];
  bit [NREQ-1:0] e_rv [D];
  bit e_err [D];
  bit [31:0] e_rd [D];
  bit [31:0] e_din [D];
  bit [2:0] e_mode [D];
  int cyc = 0;
  int idle_from = 0;
  int rr = 0;
  int cap_at = -1;
`ifdef MEMCTL_RETRY_EN
  bit hold_on = 0;
  int hstart, hg;
  bit [1:0] hop, hch;
  bit [2:0] hmd;
  bit [31:0] hwd;
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, a, e);
    end
  endtask
  function automatic int first_rr();
    for (int i = 0; i < NREQ; i++)
      if (req_valid[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return 0;
  endfunction
  task automatic post(input int g, input int r, input bit err);
    e_rv[r] = NREQ'(1) << g;
    e_err[r] = err;
    idle_from = r + 1;
  endtask
  task automatic go(input int g, input bit [1:0] op, input bit [1:0] ch, input bit [2:0] md,
                    input bit [31:0] wd, input int s);
    if (op == 2'b10) begin
      e_clr[s] = 1'b1;
      post(g, s + 1, 1'b0);
    end else begin
      e_rw[s] = op == 2'b00 ? 2'b10 : 2'b01;
      e_ce[s] = 3'b001 << ch;
      e_din[s] = wd;
      e_mode[s] = md;
      if (op == 2'b01) post(g, s + 1, 1'b0);
      else begin
        post(g, s + 1 + RD_LAT, 1'b0);
        cap_at = s + 1 + RD_LAT;
      end
    end
  endtask
  always @(posedge clk) begin
    int g;
    bit [1:0] op, ch;
    bit ill, blk;
    cyc = cyc + 1;
    if (reset) begin
      for (int i = cyc; i < D; i++) begin
        e_rw[i] = 0; e_ce[i] = 0; e_clr[i] = 0; e_rv[i] = 0;
        e_err[i] = 0; e_rd[i] = 0; e_din[i] = 0; e_mode[i] = 0;
      end
      rr = 0;
      idle_from = cyc;
      cap_at = -1;
`ifdef MEMCTL_RETRY_EN
      hold_on = 0;
`endif
    end else begin
      if (cap_at == cyc) e_rd[cyc] = Dout;
`ifdef MEMCTL_RETRY_EN
      if (hold_on) begin
        blk = hop == 2'b01 ? full : empty;
        if (!blk) begin
          go(hg, hop, hch, hmd, hwd, cyc);
          hold_on = 0;
        end else if (cyc == hstart + RETRY_MAX) begin
          post(hg, cyc, 1'b1);
          hold_on = 0;
        end
      end
`endif
      if (cyc - 1 >= idle_from && |req_valid) begin
        g = first_rr();
        rr = (g + 1) % NREQ;
        op = req_op[2*g +: 2];
        ch = req_chip[2*g +: 2];
        ill = op == 2'b11 || ch == 2'b11;
        blk = (op == 2'b01 && full) || (op == 2'b00 && empty);
        if (ill) post(g, cyc, 1'b1);
        else if (blk) begin
`ifdef MEMCTL_RETRY_EN
          hold_on = 1; hstart = cyc; hg = g; hop = op; hch = ch;
          hmd = req_mode[3*g +: 3]; hwd = req_wdata[32*g +: 32];
          idle_from = 1 << 30;
`else
          post(g, cyc, 1'b1);
`endif
        end else go(g, op, ch, req_mode[3*g +: 3], req_wdata[32*g +: 32], cyc);
      end
    end
  end
  always @(negedge clk) begin
    int m;
    logic [NREQ-1:0] er;
    m = cyc;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rw", rw, 0);
      chk("rst_chip_en", chip_en, 0);
      chk("rst_mem_reset", mem_reset, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_din", Din, 0);
      chk("rst_mode_in", mode_in, 0);
    end else begin
      er = (m >= idle_from && |req_valid) ? NREQ'(1) << first_rr() : '0;
      chk("req_ready", req_ready, er);
      chk("rw", rw, e_rw[m]);
      chk("chip_en", chip_en, e_ce[m]);
      chk("mem_reset", mem_reset, e_clr[m]);
      chk("rsp_valid", rsp_valid, e_rv[m]);
      if (e_rv[m] != 0) begin
        chk("rsp_err", rsp_err, e_err[m]);
        chk("rsp_rdata", rsp_rdata, e_rd[m]);
      end
      if (e_rw[m] != 0) begin
        chk("din", Din, e_din[m]);
        chk("mode_in", mode_in, e_mode[m]);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic idle(input int n);
    repeat (n) tick;
  endtask
  task automatic hs(input logic [NREQ-1:0] m, input string n);
    @(negedge clk);
    chk(n, req_ready, m);
    tick;
    req_valid = req_valid & ~m;
  endtask
  task automatic setr(input int i, input bit [1:0] op, input bit [1:0] ch, input bit [2:0] md,
                      input bit [31:0] wd);
    req_op[2*i +: 2] = op;
    req_chip[2*i +: 2] = ch;
    req_mode[3*i +: 3] = md;
    req_wdata[32*i +: 32] = wd;
  endtask
  initial begin
    reset = 1; req_valid = 0; req_op = 0; req_chip = 0; req_mode = 0; req_wdata = 0;
    Dout = 0; full = 0; empty = 0;
    tick;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("lit_rst_ready", req_ready, 0);
    chk("lit_rst_mem_reset", mem_reset, 1);
    tick; tick;
    req_valid = 0; reset = 0;
    tick;
    setr(0, 2'b00, 2'd1, 3'd3, 0); setr(2, 2'b00, 2'd0, 3'd2, 0);
    Dout = 32'hCAFE0001; req_valid = 4'b0101;
    hs(4'b0001, "lit_grant0");
    @(negedge clk); chk("lit_rd_rw", rw, 2'b10); chk("lit_rd_ce", chip_en, 3'b010); tick;
    @(negedge clk); chk("lit_wait_rw", rw, 2'b00); tick;
    @(negedge clk); chk("lit_rd_rv", rsp_valid, 4'b0001); chk("lit_rd_data", rsp_rdata, 32'hCAFE0001); tick;
    hs(4'b0100, "lit_grant2");
    idle(5);
    setr(1, 2'b00, 2'd0, 3'd0, 0); setr(3, 2'b00, 2'd2, 3'd0, 0);
    req_valid = 4'b1010;
    hs(4'b1000, "lit_rr3");
    idle(3);
    hs(4'b0010, "lit_rr_wrap");
    idle(4);
    setr(1, 2'b01, 2'd2, 3'd5, 32'h12345678); req_valid = 4'b0010;
    hs(4'b0010, "lit_wr_grant");
    @(negedge clk);
    chk("lit_wr_din", Din, 32'h12345678); chk("lit_wr_ce", chip_en, 3'b100);
    chk("lit_wr_rw", rw, 2'b01); chk("lit_wr_mode", mode_in, 3'd5);
    tick;
    @(negedge clk); chk("lit_wr_rv", rsp_valid, 4'b0010); chk("lit_wr_err", rsp_err, 0); tick;
    idle(2);
    full = 1; setr(2, 2'b01, 2'd0, 3'd1, 32'hDEAD0000); req_valid = 4'b0100;
    hs(4'b0100, "lit_full_grant");
`ifdef MEMCTL_RETRY_EN
    idle(3); full = 0; tick;
    @(negedge clk); chk("lit_retry_rw", rw, 2'b01); tick;
    idle(2);
    full = 1; req_valid = 4'b0100;
    hs(4'b0100, "lit_full2_grant");
    idle(15);
    @(negedge clk); chk("lit_retry_to_rv", rsp_valid, 4'b0100); chk("lit_retry_to_err", rsp_err, 1); tick;
    full = 0;
    idle(1);
`else
    @(negedge clk); chk("lit_full_err", rsp_err, 1); chk("lit_full_rw", rw, 0); tick;
    full = 0;
    idle(2);
`endif
    setr(3, 2'b00, 2'd3, 3'd0, 0); req_valid = 4'b1000;
    hs(4'b1000, "lit_chip3_grant");
    @(negedge clk); chk("lit_chip3_err", rsp_err, 1); chk("lit_chip3_rw", rw, 0); tick;
    setr(0, 2'b11, 2'd0, 3'd0, 0); req_valid = 4'b0001;
    hs(4'b0001, "lit_op3_grant");
    @(negedge clk); chk("lit_op3_rv", rsp_valid, 4'b0001); chk("lit_op3_err", rsp_err, 1); tick;
    idle(1);
    setr(1, 2'b10, 2'd0, 3'd0, 0); req_valid = 4'b0010;
    hs(4'b0010, "lit_clr_grant");
    @(negedge clk); chk("lit_clr_mr", mem_reset, 1); chk("lit_clr_ce", chip_en, 0); tick;
    @(negedge clk); chk("lit_clr_mr_end", mem_reset, 0); chk("lit_clr_rv", rsp_valid, 4'b0010); tick;
    empty = 1; setr(2, 2'b00, 2'd1, 3'd0, 0); req_valid = 4'b0100;
    hs(4'b0100, "lit_empty_grant");
`ifndef MEMCTL_RETRY_EN
    @(negedge clk); chk("lit_empty_err", rsp_err, 1);
`endif
    tick;
    empty = 0;
    idle(6);
    setr(3, 2'b00, 2'd2, 3'd4, 0); Dout = 32'h00001111; req_valid = 4'b1000;
    hs(4'b1000, "lit_cap_grant");
    empty = 1; tick;
    Dout = 32'hBEEF0002; tick;
    @(negedge clk); chk("lit_cap_data", rsp_rdata, 32'hBEEF0002); chk("lit_cap_err", rsp_err, 0); tick;
    empty = 0;
    idle(1);
    setr(0, 2'b00, 2'd0, 3'd0, 0); req_valid = 4'b0001;
    hs(4'b0001, "lit_rst_rd_grant");
    tick;
    reset = 1;
    @(negedge clk); chk("lit_abort_rw", rw, 0); chk("lit_abort_rv", rsp_valid, 0); chk("lit_abort_mr", mem_reset, 1);
    tick; tick;
    reset = 0;
    idle(3);
    for (int i = 0; i < NREQ; i++) setr(i, 2'b00, 2'd0, 3'd0, 0);
    req_valid = 4'b1111;
    hs(4'b0001, "lit_post_rst_rr");
    idle(3);
    hs(4'b0010, "lit_post_rst_g1");
    idle(3);
    hs(4'b0100, "lit_post_rst_g2");
    idle(3);
    hs(4'b1000, "lit_post_rst_g3");
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin controller that shares one 32-bit memory block (Din/Dout, mode_in, 3 chip enables, rw, full/empty, reset) between NREQ requesters. It accepts one request at a time through a valid/ready handshake and checks full/empty before touching memory. It then drives a single-cycle memory strobe and returns read data or an error on a one-hot response bus. It sits between the requesting engines and the memory ports.

## Interface
- NREQ, 4: number of requesters (2..8)
- RD_LAT, 1: cycles from read strobe to valid Dout (>=1)
- RETRY_MAX, 15: retry window in cycles; used only with MEMCTL_RETRY_EN
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready are high
- req_op  in  2*NREQ  per requester: 00 read, 01 write, 10 clear, 11 reserved
- req_chip  in  2*NREQ  target chip index 0..2; 3 is illegal
- req_mode  in  3*NREQ  value forwarded to mode_in
- req_wdata  in  32*NREQ  write data
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the owning requester
- rsp_rdata  out  32  read data, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- Din  out  32  memory write data
- mode_in  out  3  memory mode
- chip_en  out  3  one-hot chip select
- rw  out  2  00 idle, 01 write, 10 read; 11 is never driven
- mem_reset  out  1  memory reset
- Dout  in  32  memory read data
- full, empty  in  1 each  memory status

## Operation
- States: IDLE, ISSUE, WAIT, RESP (plus HOLD with MEMCTL_RETRY_EN).
- IDLE: grants the first valid requester at or after rr_ptr (wrapping modulo NREQ). req_ready is combinational, one-hot and asserted only in IDLE. On grant:
  - latches op, chip, mode and wdata;
  - sets rr_ptr to grant+1, wrapping NREQ-1 to 0.
- Error at grant (goes directly to RESP with rsp_err=1; no memory access):
  - op=11 or chip=3;
  - write while full=1;
  - read while empty=1.
- Otherwise the next state is ISSUE.
- ISSUE (exactly 1 cycle), registered outputs:
  - read/write: chip_en=1<<chip, rw=01 or 10, mode_in and Din as latched;
  - clear: mem_reset=1 for 1 cycle, rw=00, chip_en=000.
- After ISSUE: read goes to WAIT; write and clear go to RESP.
- WAIT: counts RD_LAT cycles with rw=00, then captures Dout into rsp_rdata on the final WAIT cycle's clock edge.
- RESP (1 cycle): rsp_valid[owner]=1. rsp_err is 0 on success. rsp_rdata is the captured data for reads and 0 for writes, clears and errors. Next state is IDLE.
- At most one transaction is in flight. No grants are made outside IDLE.
- Outside ISSUE: rw=00, chip_en=000, mem_reset=reset.

## Timing
- Handshake in cycle T (IDLE):
  - write/clear strobe at T+1, response at T+2;
  - read strobe at T+1, Dout sampled at the end of T+1+RD_LAT, response at T+2+RD_LAT;
  - error response at T+1.
- Minimum spacing between two grants is 2 cycles (error) and 3 cycles (write).
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, Din=0, mode_in=0, chip_en=000, rw=00, mem_reset=1 while reset is high.
- Reset mid-transaction aborts immediately (asynchronous). No response is issued, and the requester must re-request.
- full/empty are sampled only at grant. A change during ISSUE/WAIT does not alter the transaction.
- req_valid falling after the handshake has no effect. req_valid must hold until ready.

## Configuration
- MEMCTL_RETRY_EN defined: a grant blocked by full/empty enters HOLD instead of RESP.
  - HOLD re-checks the flag every cycle; on clear it goes to ISSUE.
  - After RETRY_MAX cycles still blocked, it goes to RESP with rsp_err=1.
  - Illegal op/chip still errors immediately.
- Undefined: no HOLD state; a blocked grant errors at T+1.

## Test plan
- Requesters 0 and 2 both valid after reset, reads with empty=0, Dout=0xCAFE0001 -> grant 0 first, then 2. rsp_valid at T+3 with 0xCAFE0001. Next rr_ptr=3.
- Requester 1 writes 0x12345678, chip=2, mode=5 -> at T+1 Din=0x12345678, chip_en=100, rw=01, mode_in=5. rsp_valid[1] at T+2 with err=0.
- Write with full=1, macro off -> no strobe, rsp_err=1 at T+1. Macro on with full dropping after 4 cycles -> strobe at T+5. Full held 20 cycles -> err at T+1+RETRY_MAX.
- chip=3 or op=11 -> rsp_err=1 at T+1, rw stays 00.
- Clear op -> mem_reset=1 for exactly cycle T+1, response at T+2.
- Reset asserted during WAIT -> rw=00, rsp_valid=0 immediately. After release, IDLE with rr_ptr=0 and no stale response.
